// File: rtl/reservoir_ctrl.sv
// Reservoir level controller.
// A debounced level sensor drives a six-state FSM that commands a fill
// pump and a drain valve. A descalibrated sensor that persists for too
// long escalates to a sticky FAULT, which only an operator acknowledge
// with a sane committed level can clear.
// All outputs are registered and decoded from the next state, so they
// change on the same edge as the state code.
module reservoir_ctrl #(
  parameter int unsigned DEBOUNCE     = 3,
  parameter int unsigned FAULT_CYCLES = 8
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic [1:0] sensor,
  input  logic       ack,
  output logic [7:0] SEG,
  output logic [2:0] state,
  output logic       pump,
  output logic       valve,
  output logic       alarm
);

  // Encoded state values are visible on the state port, so they are fixed.
  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_ALTO   = 3'd1,
    ST_NORMAL = 3'd2,
    ST_BAIXO  = 3'd3,
    ST_DESCAL = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  // Raw sensor codes.
  localparam logic [1:0] LVL_ALTO   = 2'b00;
  localparam logic [1:0] LVL_NORMAL = 2'b01;
  localparam logic [1:0] LVL_BAIXO  = 2'b10;
  localparam logic [1:0] LVL_DESCAL = 2'b11;

  // Saturation value of the sample counter.
  localparam logic [3:0] DEB_CNT    = 4'(DEBOUNCE);

  // Value of fcnt on the edge that escalates DESCAL into FAULT.
  localparam logic [7:0] FAULT_LAST = 8'(FAULT_CYCLES - 1);

  // Seven-segment patterns shown for each state.
  localparam logic [7:0] SEG_INIT   = 8'h40;
  localparam logic [7:0] SEG_ALTO   = 8'h5F;
  localparam logic [7:0] SEG_NORMAL = 8'h54;
  localparam logic [7:0] SEG_BAIXO  = 8'h7C;
  localparam logic [7:0] SEG_DESCAL = 8'h5E;
  localparam logic [7:0] SEG_FAULT  = 8'h71;

  // Debouncer state.
  logic [1:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic       commit;

  // Last committed level. FAULT needs it to decide where to exit to.
  // It resets to the descalibrated code so that a stray ack cannot
  // release FAULT before any real level has been seen.
  logic [1:0] lvl_q, lvl_d;

  // FSM state and the counter that times how long DESCAL has lasted.
  state_t     state_q, state_d;
  logic [7:0] fcnt_q, fcnt_d;

  // Registered outputs.
  logic [7:0] seg_q, seg_d;
  logic       pump_q, pump_d;
  logic       valve_q, valve_d;
  logic       alarm_q, alarm_d;

  // Maps a committed sensor code to the state it selects.
  function automatic state_t level_state(input logic [1:0] lvl);
    state_t st;
    case (lvl)
      LVL_ALTO:   st = ST_ALTO;
      LVL_NORMAL: st = ST_NORMAL;
      LVL_BAIXO:  st = ST_BAIXO;
      default:    st = ST_DESCAL;
    endcase
    return st;
  endfunction

  // Debouncer: track the candidate value and count how many consecutive
  // edges have seen it. A commit fires only on the edge where the count
  // first reaches DEBOUNCE. Once saturated nothing fires again until the
  // sensor changes. With DEBOUNCE=1 a change commits on its first edge.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    commit = 1'b0;
    if (sensor != cand_q) begin
      cand_d = sensor;
      cnt_d  = 4'd1;
      commit = (DEB_CNT == 4'd1);
    end else if (cnt_q != DEB_CNT) begin
      cnt_d  = cnt_q + 4'd1;
      commit = ((cnt_q + 4'd1) == DEB_CNT);
    end
  end

  // Committed level follows the sensor on every commit, in any state.
  always_comb begin
    lvl_d = lvl_q;
    if (commit) begin
      lvl_d = sensor;
    end
  end

  // Next-state logic.
  // FAULT ignores commits and leaves only on ack with a sane level.
  // In DESCAL the timeout takes priority over a commit on the same edge.
  // The other states simply follow each commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FAULT: begin
        if (ack && (lvl_d != LVL_DESCAL)) begin
          state_d = level_state(lvl_d);
        end
      end
      ST_DESCAL: begin
        if (fcnt_q == FAULT_LAST) begin
          state_d = ST_FAULT;
        end else if (commit) begin
          state_d = level_state(sensor);
        end
      end
      ST_INIT, ST_ALTO, ST_NORMAL, ST_BAIXO: begin
        if (commit) begin
          state_d = level_state(sensor);
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // The DESCAL timer counts edges spent in DESCAL. It restarts from zero
  // on entry, and it clears whenever DESCAL is left or not occupied.
  always_comb begin
    fcnt_d = 8'd0;
    if ((state_q == ST_DESCAL) && (state_d == ST_DESCAL)) begin
      fcnt_d = fcnt_q + 8'd1;
    end
  end

  // Output decode from the next state.
  // Pump and valve come from disjoint states, so they can never both be
  // asserted.
  always_comb begin
    seg_d   = SEG_INIT;
    pump_d  = 1'b0;
    valve_d = 1'b0;
    alarm_d = 1'b0;
    case (state_d)
      ST_INIT:   seg_d = SEG_INIT;
      ST_ALTO: begin
        seg_d   = SEG_ALTO;
        valve_d = 1'b1;
      end
      ST_NORMAL: seg_d = SEG_NORMAL;
      ST_BAIXO: begin
        seg_d  = SEG_BAIXO;
        pump_d = 1'b1;
      end
      ST_DESCAL: seg_d = SEG_DESCAL;
      ST_FAULT: begin
        seg_d   = SEG_FAULT;
        alarm_d = 1'b1;
      end
      default:   seg_d = SEG_INIT;
    endcase
  end

  // Debouncer and committed-level registers.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      cand_q <= 2'b00;
      cnt_q  <= 4'd0;
      lvl_q  <= LVL_DESCAL;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
    end
  end

  // FSM state and DESCAL timer registers.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      fcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Output registers, forced to INIT values while reset is asserted.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      seg_q   <= SEG_INIT;
      pump_q  <= 1'b0;
      valve_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      seg_q   <= seg_d;
      pump_q  <= pump_d;
      valve_q <= valve_d;
      alarm_q <= alarm_d;
    end
  end

  assign SEG   = seg_q;
  assign state = state_q;
  assign pump  = pump_q;
  assign valve = valve_q;
  assign alarm = alarm_q;

endmodule
